// File: rtl/mem_port_model.sv
// mem_port_model: wait-state-capable word-array memory responder with byte enables, stalls and error reporting
module mem_port_model #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [ADDR_W-1:0]   iMemAddr,
    input  logic [DATA_W-1:0]   iMemData,
    input  logic [DATA_W/8-1:0] iByteEn,
    input  logic                iMemRead,
    input  logic                iMemWrite,
    input  logic                iStall,
    output logic [DATA_W-1:0]   oMemData,
    output logic                oRdy,
    output logic                oErr
);
    localparam int NB = DATA_W / 8;
    localparam int AL = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * NB);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [NB-1:0]       r_be;
    logic                r_rd;
    logic                r_wr;
    logic [DATA_W-1:0]   r_odata;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_idle;
    logic                w_strobe;
    logic                w_go;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic [NB-1:0]       w_be;
    logic                w_rd;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_off;
    logic [IW-1:0]       w_idx;
    logic                w_valid;
    logic                w_err;
    logic                w_rd_ok;
    logic                w_wr_ok;

    // In IDLE a request may go straight to RESP, so the access uses the live bus; otherwise the latched copy
    always_comb begin
        w_idle   = r_state == S_IDLE;
        w_strobe = iMemRead | iMemWrite;
        w_addr   = w_idle ? iMemAddr : r_addr;
        w_data   = w_idle ? iMemData : r_data;
        w_be     = w_idle ? iByteEn : r_be;
        w_rd     = w_idle ? iMemRead : r_rd;
        w_wr     = w_idle ? iMemWrite : r_wr;
        w_off    = w_addr - BASE;
        w_idx    = IW'(w_off >> AL);
        w_valid  = (w_addr >= BASE) && ({1'b0, w_off} < SPAN) && ((w_off & ALIGN_MASK) == '0);
        w_err    = (w_rd && w_wr) || !w_valid;
        w_rd_ok  = w_rd && !w_err;
        w_wr_ok  = w_wr && !w_err;
        w_next   = r_state == S_RESP ? S_IDLE :
                   r_state == S_WAIT ? ((!iStall && r_cnt <= 8'd1) ? S_RESP : S_WAIT) :
                   w_strobe ? ((WAIT_STATES > 0 || iStall) ? S_WAIT : S_RESP) : S_IDLE;
        w_go     = (r_state != S_RESP) && (w_next == S_RESP);
    end

    // State register, wait counter and request capture
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_be    <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_idle && w_strobe) begin
                r_cnt  <= 8'(WAIT_STATES);
                r_addr <= iMemAddr;
                r_data <= iMemData;
                r_be   <= iByteEn;
                r_rd   <= iMemRead;
                r_wr   <= iMemWrite;
            end else if (r_state == S_WAIT && !iStall && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Response data and error flag, updated on the edge entering RESP; error flag self-clears after one cycle
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_odata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_go && w_err;
            if (w_go && w_rd_ok)
                r_odata <= r_mem[w_idx];
            else if (w_go && w_rd)
                r_odata <= '0;
        end
    end

    // Byte-lane write commit; array is never cleared and reset blocks a pending commit
    always_ff @(posedge iClk) begin
        if (!iRst && w_go && w_wr_ok)
            for (int b = 0; b < NB; b++)
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
    end

    assign oMemData = r_odata;
    assign oRdy     = r_state == S_RESP;
    assign oErr     = r_err;
endmodule

// File: tb/tb_mem_port_model.sv
// tb_mem_port_model: scoreboard bench over three responders with 0, 3 and 1 wait states
module tb_mem_port_model;
    logic        clk = 1'b0;
    logic [2:0]  rst = '1;
    logic [2:0]  mr = '0;
    logic [2:0]  mw = '0;
    logic [2:0]  st = '0;
    logic [31:0] ma [3];
    logic [31:0] md [3];
    logic [3:0]  mb [3];
    logic [31:0] od [3];
    logic [2:0]  ordy;
    logic [2:0]  oerr;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        int          g;
        logic [31:0] d;
        logic        e;
        int          issue;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mem [int];
    logic [31:0] last_d [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_model #(
            .DATA_W(32), .ADDR_W(32), .DEPTH(2048), .BASE_ADDR(32'h0),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 1))
        ) u_dut (
            .iClk(clk), .iRst(rst[g]), .iMemAddr(ma[g]), .iMemData(md[g]), .iByteEn(mb[g]),
            .iMemRead(mr[g]), .iMemWrite(mw[g]), .iStall(st[g]),
            .oMemData(od[g]), .oRdy(ordy[g]), .oErr(oerr[g])
        );
    end

    function automatic int ws(input int g);
        return g == 0 ? 0 : (g == 1 ? 3 : 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every oRdy pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 3; g++) begin
            if (oerr[g] && !ordy[g]) check("err_without_rdy", 32'd1, 32'd0);
            if (ordy[g]) begin
                if (sb.size() == 0) check("unexpected_rdy", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check("rdy_port", g, e.g);
                    check("rdata", od[g], e.d);
                    check("err", {31'd0, oerr[g]}, {31'd0, e.e});
                    check("latency", cyc - e.issue, e.lat);
                end
            end
        end
    end

    task automatic do_reset(input int g);
        @(negedge clk);
        rst[g] = 1'b1; mr[g] = 1'b0; mw[g] = 1'b0; st[g] = 1'b0;
        repeat (2) @(negedge clk);
        rst[g] = 1'b0;
        last_d[g] = '0;
        check("rst_rdy", {31'd0, ordy[g]}, 32'd0);
        check("rst_err", {31'd0, oerr[g]}, 32'd0);
        check("rst_data", od[g], 32'd0);
    endtask

    task automatic req(input int g, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input int stall,
                       input bit b2b, input bit keep);
        exp_t        e;
        logic [31:0] t;
        int          idx;
        bit          ok;
        int          n;
        if (!b2b) @(negedge clk);
        mr[g] = rd; mw[g] = wr; ma[g] = a; md[g] = d; mb[g] = be;
        ok  = (a[1:0] == 2'b00) && (a < 32'h2000);
        idx = g * 65536 + int'(a >> 2);
        e.g = g; e.issue = b2b ? cyc + 2 : cyc + 1; e.lat = ws(g) + stall;
        if ((rd && wr) || !ok) begin
            e.e = 1'b1; e.d = rd ? 32'd0 : last_d[g];
        end else if (rd) begin
            e.e = 1'b0; e.d = mem[idx];
        end else begin
            e.e = 1'b0; e.d = last_d[g];
            t = mem.exists(idx) ? mem[idx] : 32'd0;
            for (int b = 0; b < 4; b++) if (be[b]) t[8*b +: 8] = d[8*b +: 8];
            mem[idx] = t;
        end
        last_d[g] = e.d;
        sb.push_back(e);
        if (stall > 0) begin
            @(negedge clk);
            st[g] = 1'b1;
            repeat (stall) @(negedge clk);
            st[g] = 1'b0;
        end else @(negedge clk);
        n = 0;
        while (!ordy[g] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ordy[g]) check("timeout", 32'd0, 32'd1);
        if (!keep) begin
            mr[g] = 1'b0; mw[g] = 1'b0;
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            ma[g] = '0; md[g] = '0; mb[g] = '0; last_d[g] = '0;
        end
        do_reset(0);
        do_reset(1);
        do_reset(2);
        req(0, 0, 1, 32'h1000, 32'h0000_0002, 4'hF, 0, 0, 0);
        req(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, 0, 0);
        req(0, 0, 1, 32'h1000, 32'h1122_3344, 4'hF, 0, 0, 0);
        req(0, 0, 1, 32'h1000, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
        req(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, 0, 0);
        req(0, 0, 1, 32'h1004, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        req(0, 0, 1, 32'h1004, 32'h0, 4'h0, 0, 0, 0);
        req(0, 1, 0, 32'h1004, 32'h0, 4'h0, 0, 0, 0);
        req(0, 1, 0, 32'h1002, 32'h0, 4'h0, 0, 0, 0);
        req(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, 0, 0);
        req(0, 1, 0, 32'h2000, 32'h0, 4'h0, 0, 0, 0);
        req(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, 0, 0);
        req(0, 1, 1, 32'h1000, 32'h0000_DEAD, 4'hF, 0, 0, 0);
        req(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, 0, 0);
        req(0, 0, 1, 32'h1FFC, 32'hA5A5_A5A5, 4'hF, 0, 0, 0);
        req(0, 1, 0, 32'h1FFC, 32'h0, 4'h0, 0, 0, 0);
        req(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, 0, 1);
        req(0, 1, 0, 32'h1004, 32'h0, 4'h0, 0, 1, 1);
        req(0, 0, 1, 32'h1000, 32'h1234_5678, 4'hF, 0, 1, 0);
        req(0, 1, 0, 32'h1000, 32'h0, 4'h0, 0, 0, 0);
        req(1, 0, 1, 32'h1004, 32'h0000_0001, 4'hF, 0, 0, 0);
        req(1, 1, 0, 32'h1004, 32'h0, 4'h0, 0, 0, 0);
        req(2, 0, 1, 32'h1008, 32'h0000_0077, 4'hF, 0, 0, 0);
        req(2, 1, 0, 32'h1008, 32'h0, 4'h0, 5, 0, 0);
        @(negedge clk);
        mw[2] = 1'b1; ma[2] = 32'h1008; md[2] = 32'h0000_0099; mb[2] = 4'hF;
        @(negedge clk);
        st[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b1;
        repeat (2) @(negedge clk);
        rst[2] = 1'b0; mw[2] = 1'b0; st[2] = 1'b0; last_d[2] = '0;
        check("abort_rdy", {31'd0, ordy[2]}, 32'd0);
        check("abort_data", od[2], 32'd0);
        repeat (3) @(negedge clk);
        req(2, 1, 0, 32'h1008, 32'h0, 4'h0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_model.md
Name: mem_port_model

Overview:
- Parametrised, wait-state-capable memory responder for the processor's data/instruction bus.
- Generalises the fixed address-decoded memory stub into a sized word array with:
  - configurable base address and depth
  - byte enables
  - injected stalls
  - error reporting on the oRdy/iRdy handshake
- Sits between the processor port (oMemAddr/oMemData/oMemRead/oMemWrite, iRdy) and nothing else. Used in benches and as the simple on-chip RAM in small builds.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8.
- ADDR_W, 32, byte address width.
- DEPTH, 1024, number of DATA_W words in the array; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*DATA_W/8.
- WAIT_STATES, 0, fixed extra cycles before each response (0..255).

Ports:
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  synchronous active-high reset
- iMemAddr  in  ADDR_W  byte address of request
- iMemData  in  DATA_W  write data
- iByteEn  in  DATA_W/8  byte lane enables for writes; ignored for reads
- iMemRead  in  1  read strobe
- iMemWrite  in  1  write strobe
- iStall  in  1  bench-driven stall; extends wait phase while high
- oMemData  out  DATA_W  read data, registered, valid when oRdy=1
- oRdy  out  1  one-cycle response pulse (drives processor iRdy)
- oErr  out  1  error flag, valid only with oRdy

Behaviour:
- Reset:
  - Synchronous, on iRst=1 at rising edge: state=IDLE, oRdy=0, oErr=0, oMemData=0, wait counter=0.
  - Array contents are not cleared.
  - Reset mid-request aborts it: no write is committed, no oRdy.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Samples iMemRead|iMemWrite at each edge.
  - On a strobe, latches addr, data, byte enables and op.
  - Loads counter=WAIT_STATES.
  - Goes to WAIT if WAIT_STATES>0 or iStall=1, else RESP.
- WAIT:
  - Decrements counter each edge while iStall=0.
  - Holds while iStall=1.
  - Goes to RESP on the edge where counter==1 with iStall=0, or when counter==0 and iStall falls.
- RESP:
  - oRdy=1 for exactly this cycle; goes to IDLE at next edge.
  - Strobes are ignored in RESP.
- Latency:
  - Strobe sampled at edge N gives oRdy high during the cycle after edge N+WAIT_STATES+(stall cycles).
  - Minimum latency is 1 cycle.
- Requester protocol:
  - Hold strobes and address stable until oRdy is seen.
  - Drop strobes by the edge after oRdy.
  - A strobe still high in IDLE is a new request; back-to-back requests are legal.
- Decode:
  - index = (addr-BASE_ADDR) >> log2(DATA_W/8).
  - Valid iff BASE_ADDR <= addr < BASE_ADDR+DEPTH*DATA_W/8 and addr low log2(DATA_W/8) bits == 0.
- Read, valid: oMemData <= array[index] at the edge entering RESP, oErr=0.
- Write, valid:
  - array[index] byte lane b <= data lane b for each iByteEn[b]=1, committed at the edge entering RESP.
  - oMemData holds its previous value; oErr=0.
  - iByteEn=0 is legal: no change, oErr=0.
- Error cases, all of which respond with oRdy=1, oErr=1 and no array change:
  - out-of-range or misaligned address: oMemData=0 on reads
  - iMemRead and iMemWrite both high: treated as an error, oMemData=0
- oMemData holds its value between responses. oErr is 0 whenever oRdy=0.
- Read-after-write to the same word in consecutive requests returns the new data.
- No internal buffering: exactly one outstanding request.

Test Plan:
- Reset then read: iRst high 2 cycles; preload word 0x400=32'h2 via write; read addr 0x1000 (BASE_ADDR=0) -> oRdy one cycle later, oMemData=32'h0000_0002, oErr=0.
- Wait states: WAIT_STATES=3, read 0x1004 holding 32'h1 -> oRdy exactly 4 cycles after strobe edge, single-cycle pulse, data 32'h1.
- Byte-enable write: write 32'hAABBCCDD to 0x1000 with iByteEn=4'b0101 over 32'h11223344 -> readback 32'h11BB33DD.
- Stall injection: WAIT_STATES=1, iStall high 5 cycles after request -> oRdy 7 cycles after strobe edge. Reset asserted during WAIT of a write -> no oRdy, array unchanged on readback.
- Errors: read 0x1002 (misaligned), read BASE_ADDR+4*DEPTH (out of range), read+write together -> each gives oRdy=1, oErr=1, oMemData=0, and the target word is unchanged.
- Back-to-back: load 0x1000, load 0x1004, store 0x1000 with strobes held continuously -> three distinct oRdy pulses separated by one IDLE cycle each, final readback equals stored data.
